// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: the I-cache and the D-cache share one memory port, and one grant is held until mem_ready.
// Optional MEM_ARB_RR_EN: when both caches request at once, the side that was not served last wins.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    mem_req_t   i_req, d_req, fwd;
    logic [1:0] state, state_nxt;
    logic       req_i, req_d, pick_i;

    assign i_req = {i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata};
    assign d_req = {d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata};
    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;

`ifdef MEM_ARB_RR_EN
    // lg remembers which side completed last (1 means D); it breaks ties in favour of the other side
    logic lg;

    always_ff @(posedge clk) begin
        if (proc_reset)
            lg <= 1'b0;
        else if (mem_ready && state == GNT_I)
            lg <= 1'b0;
        else if (mem_ready && state == GNT_D)
            lg <= 1'b1;
    end

    assign pick_i = req_i & (~req_d | lg);
`else
    assign pick_i = req_i & ~req_d;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_i)
                    state_nxt = GNT_I;
                else if (req_d)
                    state_nxt = GNT_D;
            end
            GNT_I, GNT_D: begin
                if (mem_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The grant holds even if the owner drops its request early; memory then sees an empty request
    always_comb begin
        fwd = '0;
        case (state)
            GNT_I:   fwd = i_req;
            GNT_D:   fwd = d_req;
            default: fwd = '0;
        endcase
    end

    assign mem_read    = fwd.rd;
    assign mem_write   = fwd.wr;
    assign mem_addr    = fwd.addr;
    assign mem_wdata   = fwd.wdata;

    assign i_mem_ready = (state == GNT_I) & mem_ready;
    assign d_mem_ready = (state == GNT_D) & mem_ready;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

endmodule
